// File: rtl/probe_frame_assembler.sv
// probe_frame_assembler
// Packs narrow probe words into one DATA_WIDTH frame with a 32-bit header and
// hands it to the C2H packetiser over a data/data_valid/data_next handshake.
//
// Storage is two stages. The assembly buffer (ASM) collects words and the
// output register (OUT) holds the frame on offer, so the next frame can fill
// while the consumer is still busy with the current one.
//
// Ports
//   m_axis_c2h_aclk     clock
//   m_axis_c2h_aresetn  asynchronous active-low reset
//   in_data/in_valid    probe word in; accepted when in_valid & in_ready
//   in_ready            high while the ASM is filling
//   flush               one-cycle request to close a partial frame
//   data/data_valid     frame out; transferred when data_valid & data_next
//   data_next           consumer ready
//   fill_level          words held in the ASM
//   frames_sent         transferred frames, wraps
//
// Frame header: [15:0] seq, [23:16] slot count, [24] flush-closed,
// [25] timeout-closed, [31:26] zero. Slot i sits at 32+i*IN_WIDTH.
//
// Optional build macro PROBE_FRAME_TIMEOUT_EN: when defined, a partial frame
// that sits idle for TIMEOUT_CYCLES cycles is closed with header bit 25 set.
//
// state     | meaning
// ST_FILL   | ASM accepting words
// ST_CLOSED | ASM frame complete, waiting for OUT to be free

module probe_frame_assembler #(
    parameter int DATA_WIDTH     = 16000,
    parameter int IN_WIDTH       = 1000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  m_axis_c2h_aclk,
    input  logic                  m_axis_c2h_aresetn,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_next,
    output logic [7:0]            fill_level,
    output logic [15:0]           frames_sent
);

    localparam int         SLOTS     = (DATA_WIDTH - 32) / IN_WIDTH;
    localparam int         ASM_W     = (SLOTS > 0) ? SLOTS * IN_WIDTH : 1;
    localparam logic [7:0] LAST_SLOT = 8'(SLOTS - 1);

    generate
        if (SLOTS < 1 || SLOTS > 255) begin : g_bad_slots
            $error("probe_frame_assembler: SLOTS must be 1..255");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("probe_frame_assembler: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic {ST_FILL, ST_CLOSED} asm_state_e;

    asm_state_e            state_q, state_d;
    logic [ASM_W-1:0]      asm_q, asm_d;
    logic [7:0]            fill_q, fill_d;
    logic                  flush_cl_q, flush_cl_d;
    logic                  tmo_cl_q, tmo_cl_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [15:0]           seq_q, seq_d;
    logic [15:0]           sent_q, sent_d;
    logic [DATA_WIDTH-1:0] frame;
    logic                  accept;
    logic                  take;

`ifdef PROBE_FRAME_TIMEOUT_EN
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0]            idle_q, idle_d;
`endif

    // Gated by reset so the upstream sees not-ready while the block is held.
    assign in_ready    = m_axis_c2h_aresetn & (state_q == ST_FILL);
    assign accept      = in_valid & in_ready;
    assign take        = valid_q & data_next;
    assign data        = data_q;
    assign data_valid  = valid_q;
    assign fill_level  = fill_q;
    assign frames_sent = sent_q;

    always_comb begin
        frame           = '0;
        frame[15:0]     = seq_q;
        frame[23:16]    = fill_q;
        frame[24]       = flush_cl_q;
        frame[25]       = tmo_cl_q;
        frame[32 +: ASM_W] = asm_q;
    end

    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        fill_d     = fill_q;
        flush_cl_d = flush_cl_q;
        tmo_cl_d   = tmo_cl_q;
        data_d     = data_q;
        valid_d    = valid_q;
        seq_d      = seq_q;
        sent_d     = sent_q;
`ifdef PROBE_FRAME_TIMEOUT_EN
        idle_d     = idle_q;
`endif

        if (take) begin
            valid_d = 1'b0;
            sent_d  = sent_q + 16'd1;
        end

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    asm_d[fill_q*IN_WIDTH +: IN_WIDTH] = in_data;
                    fill_d = fill_q + 8'd1;
                end
                // A full frame wins over a coincident flush: flag stays clear.
                if (accept && fill_q == LAST_SLOT) begin
                    state_d = ST_CLOSED;
                end else if (flush && (fill_q != 8'd0 || accept)) begin
                    state_d    = ST_CLOSED;
                    flush_cl_d = 1'b1;
                end
`ifdef PROBE_FRAME_TIMEOUT_EN
                if (state_d == ST_CLOSED || accept || fill_q == 8'd0) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d  = ST_CLOSED;
                    tmo_cl_d = 1'b1;
                    idle_d   = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            ST_CLOSED: begin
                // OUT may be reloaded on the same edge its current frame leaves.
                if (!valid_q || take) begin
                    data_d     = frame;
                    valid_d    = 1'b1;
                    seq_d      = seq_q + 16'd1;
                    state_d    = ST_FILL;
                    asm_d      = '0;
                    fill_d     = 8'd0;
                    flush_cl_d = 1'b0;
                    tmo_cl_d   = 1'b0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            state_q    <= ST_FILL;
            asm_q      <= '0;
            fill_q     <= 8'd0;
            flush_cl_q <= 1'b0;
            tmo_cl_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            seq_q      <= 16'd0;
            sent_q     <= 16'd0;
`ifdef PROBE_FRAME_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            fill_q     <= fill_d;
            flush_cl_q <= flush_cl_d;
            tmo_cl_q   <= tmo_cl_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            seq_q      <= seq_d;
            sent_q     <= sent_d;
`ifdef PROBE_FRAME_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

endmodule
